// File: rtl/sqrt_pkg.sv
// sqrt_pkg: widths and FSM encoding shared by the integer square-root unit and its squarer.
package sqrt_pkg;
    localparam int ROOT_W = 4;
    localparam int RES_W  = 2 * ROOT_W;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/square_seq.sv
// square_seq: shift-add squarer, one partial product per clock with start/ready handshake.
// Define SQUARE_SEQ_REM_EN to add rem_i and produce a*a + rem (radicand reconstruction).
module square_seq
    import sqrt_pkg::*;
#(
    parameter int W = ROOT_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
`ifdef SQUARE_SEQ_REM_EN
    input  logic [W:0]     rem_i,
`endif
    output logic           busy_o,
    output logic           ready_o,
    output logic [2*W-1:0] result_o
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    state_t         state, state_nxt;
    logic [2*W-1:0] m, acc, acc_nxt, acc_init;
    logic [W-1:0]   q;
    logic [CW-1:0]  i;
    logic           last, accept;
    always_comb begin
        last     = i == CW'(W - 1);
        accept   = (state != CALC) && start_i;
        acc_nxt  = acc + (q[i] ? (m << i) : '0);
`ifdef SQUARE_SEQ_REM_EN
        acc_init = (2*W)'(rem_i);
`else
        acc_init = '0;
`endif
    end
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == CALC) ? (last ? DONE : CALC) : (start_i ? CALC : state);
    end
    always_comb begin
        busy_o  = state == CALC;
        ready_o = state == DONE;
    end
    // result_o is only written on completion, so a restart keeps the old value visible
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m        <= '0;
            q        <= '0;
            acc      <= '0;
            i        <= '0;
            result_o <= '0;
        end else if (accept) begin
            m   <= (2*W)'(a_i);
            q   <= a_i;
            acc <= acc_init;
            i   <= '0;
        end else if (state == CALC) begin
            acc <= acc_nxt;
            i   <= i + 1'b1;
            if (last)
                result_o <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_square_seq.sv
// tb_square_seq: directed self-checking bench for square_seq, one task per scenario.
module tb_square_seq;
    localparam int W = 4;
    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic [W-1:0]   a_i = '0;
`ifdef SQUARE_SEQ_REM_EN
    logic [W:0]     rem_i = '0;
`endif
    logic           busy_o, ready_o;
    logic [2*W-1:0] result_o;
    int             errors = 0;
    int             checks = 0;

    square_seq #(.W(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
`ifdef SQUARE_SEQ_REM_EN
        .rem_i   (rem_i),
`endif
        .busy_o  (busy_o),
        .ready_o (ready_o),
        .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [W-1:0] a);
        a_i     = a;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_ready(inout int cyc);
        while (!ready_o && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy_o, ready_o, result_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b ready=%0b result=%0d, want 0 0 0", busy_o, ready_o, result_o);
        end
        rst_i = 1'b0;
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b ready=%0b, want 0 0", busy_o, ready_o);
        end
    endtask

    task automatic test_basic();
        int cyc;
        pulse(4'd9);
        for (int k = 1; k <= W; k++) begin
            checks++;
            if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy_c%0d: busy=%0b ready=%0b, want 1 0", k, busy_o, ready_o);
            end
            if (k == 2) a_i = 4'd2;
            tick();
        end
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || result_o !== 8'd81) begin
            errors++;
            $display("FAIL basic_done: ready=%0b busy=%0b result=%0d, want 1 0 81", ready_o, busy_o, result_o);
        end
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            a_i = 4'(k);
            tick();
            if (ready_o !== 1'b1 || result_o !== 8'd81) cyc++;
        end
        checks++;
        if (cyc != 0) begin
            errors++;
            $display("FAIL basic_hold: %0d unstable idle cycles, want 0", cyc);
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0]   av [2] = '{4'd0, 4'd15};
        logic [2*W-1:0] ev [2] = '{8'd0, 8'd225};
        int cyc;
        for (int n = 0; n < 2; n++) begin
            pulse(av[n]);
            cyc = 0;
            wait_ready(cyc);
            checks++;
            if (cyc != W || result_o !== ev[n]) begin
                errors++;
                $display("FAIL boundary_a%0d: cycles=%0d result=%0d, want %0d %0d", av[n], cyc, result_o, W, ev[n]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        pulse(4'd5);
        tick();
        a_i     = 4'd12;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 2;
        wait_ready(cyc);
        checks++;
        if (cyc != W || result_o !== 8'd25) begin
            errors++;
            $display("FAIL ignore_start: cycles=%0d result=%0d, want %0d 25", cyc, result_o, W);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        pulse(4'd3);
        cyc = 0;
        wait_ready(cyc);
        checks++;
        if (result_o !== 8'd9) begin
            errors++;
            $display("FAIL b2b_first: result=%0d, want 9", result_o);
        end
        pulse(4'd7);
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b1 || result_o !== 8'd9) begin
            errors++;
            $display("FAIL b2b_restart: ready=%0b busy=%0b result=%0d, want 0 1 9", ready_o, busy_o, result_o);
        end
        cyc = 0;
        wait_ready(cyc);
        checks++;
        if (cyc != W || result_o !== 8'd49) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d result=%0d, want %0d 49", cyc, result_o, W);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        pulse(4'd11);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({busy_o, ready_o, result_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%0b ready=%0b result=%0d, want 0 0 0", busy_o, ready_o, result_o);
        end
        tick();
        tick();
        checks++;
        if ({busy_o, ready_o, result_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%0b ready=%0b result=%0d, want 0 0 0", busy_o, ready_o, result_o);
        end
        pulse(4'd11);
        cyc = 0;
        wait_ready(cyc);
        checks++;
        if (cyc != W || result_o !== 8'd121) begin
            errors++;
            $display("FAIL reset_mid_rerun: cycles=%0d result=%0d, want %0d 121", cyc, result_o, W);
        end
    endtask

`ifdef SQUARE_SEQ_REM_EN
    task automatic test_rem();
        int cyc, r, bad;
        rem_i = 5'd30;
        pulse(4'd15);
        cyc = 0;
        wait_ready(cyc);
        checks++;
        if (cyc != W || result_o !== 8'd255) begin
            errors++;
            $display("FAIL rem_15_30: cycles=%0d result=%0d, want %0d 255", cyc, result_o, W);
        end
        rem_i = 5'd3;
        pulse(4'd4);
        cyc = 0;
        wait_ready(cyc);
        checks++;
        if (result_o !== 8'd19) begin
            errors++;
            $display("FAIL rem_4_3: result=%0d, want 19", result_o);
        end
        bad = 0;
        for (int x = 0; x < 256; x++) begin
            r = 0;
            while ((r + 1) * (r + 1) <= x) r++;
            rem_i = 5'(x - r * r);
            pulse(4'(r));
            cyc = 0;
            wait_ready(cyc);
            if (result_o !== 8'(x)) begin
                bad++;
                if (bad < 5) $display("FAIL roundtrip_x%0d: result=%0d, want %0d", x, result_o, x);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL roundtrip: %0d bad values, want 0", bad);
        end
        rem_i = '0;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SQUARE_SEQ_REM_EN
        test_rem();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
